clk_divider_prog: RTL and testbench



---
 rtl/clk_divider_pkg.sv | 24 ++
 rtl/clk_divider_prog.sv | 127 ++++++++++++
 tb/tb_clk_divider_prog.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/clk_divider_pkg.sv
// ============================================================================
// Module   : clk_divider_pkg
// Desc     : Shared types, constants and ratio clamp for clk_divider_prog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_divider_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_DIV = 2;

    // A ratio of 1 cannot produce a toggling output, so it is promoted to 2.
    function automatic logic [31:0] eff_div(input logic [31:0] n);
        return (n == 32'd1) ? 32'(MIN_DIV) : n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_divider_prog.sv
// ============================================================================
// Module   : clk_divider_prog
// Desc     : Runtime-programmable integer clock divider with per-period tick.
//            Optional macro CLKDIV_SYNC_IN_EN adds a sync_in period restart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_divider_prog
    import clk_divider_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int RST_DIV = 2
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             en,
`ifdef CLKDIV_SYNC_IN_EN
    input  logic             sync_in,
`endif
    input  logic [DIV_W-1:0] div_ratio,
    output logic             out_clk,
    output logic             out_tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             running
);

    state_t             r_state;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_cur_div;
    logic               r_out_clk;
    logic               r_out_tick;

    state_t             w_state_nxt;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [DIV_W-1:0]   w_cur_div_nxt;
    logic               w_out_clk_nxt;
    logic               w_out_tick_nxt;
    logic               w_restart;
    logic               w_stop;
    logic               w_sync;
    logic               w_ratio_nz;
    logic               w_boundary;
    logic [DIV_W-1:0]   w_cnt_inc;
    logic [DIV_W-1:0]   w_high_len;
    logic [DIV_W-1:0]   w_eff;

`ifdef CLKDIV_SYNC_IN_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    assign w_ratio_nz = (div_ratio != '0);
    assign w_eff      = DIV_W'(eff_div(32'(div_ratio)));
    assign w_boundary = (r_cnt == (r_cur_div - DIV_W'(1)));
    assign w_cnt_inc  = r_cnt + DIV_W'(1);
    // ceil(cur_div/2) written so it cannot overflow at the top ratio
    assign w_high_len = r_cur_div - (r_cur_div >> 1);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_div_nxt  = r_cur_div;
        w_out_clk_nxt  = 1'b0;
        w_out_tick_nxt = 1'b0;
        w_restart      = 1'b0;
        w_stop         = 1'b0;

        case (r_state)
            IDLE: begin
                if (en && w_ratio_nz) begin
                    w_restart = 1'b1;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    w_stop = 1'b1;
                end else if (w_sync || w_boundary) begin
                    w_restart = w_ratio_nz;
                    w_stop    = !w_ratio_nz;
                end else begin
                    w_cnt_nxt     = w_cnt_inc;
                    w_out_clk_nxt = (w_cnt_inc < w_high_len);
                end
            end
            default: w_stop = 1'b1;
        endcase

        if (w_restart) begin
            w_state_nxt    = RUN;
            w_cnt_nxt      = '0;
            w_cur_div_nxt  = w_eff;
            w_out_clk_nxt  = 1'b1;
            w_out_tick_nxt = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cur_div  <= DIV_W'(RST_DIV);
            r_out_clk  <= 1'b0;
            r_out_tick <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_div  <= w_cur_div_nxt;
            r_out_clk  <= w_out_clk_nxt;
            r_out_tick <= w_out_tick_nxt;
        end
    end

    assign out_clk  = r_out_clk;
    assign out_tick = r_out_tick;
    assign cur_div  = r_cur_div;
    assign running  = (r_state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_clk_divider_prog.sv
// ============================================================================
// Module   : tb_clk_divider_prog
// Desc     : Directed self-checking bench for clk_divider_prog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_divider_prog;

    localparam int DIV_W = 16;

    logic             in_clk;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div_ratio;
    logic             out_clk;
    logic             out_tick;
    logic [DIV_W-1:0] cur_div;
    logic             running;
`ifdef CLKDIV_SYNC_IN_EN
    logic             sync_in;
`endif

    int n_vec = 0;
    int n_err = 0;

    clk_divider_prog #(
        .DIV_W   (DIV_W),
        .RST_DIV (2)
    ) u_dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .en        (en),
`ifdef CLKDIV_SYNC_IN_EN
        .sync_in   (sync_in),
`endif
        .div_ratio (div_ratio),
        .out_clk   (out_clk),
        .out_tick  (out_tick),
        .cur_div   (cur_div),
        .running   (running)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance one in_clk edge and settle before sampling.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    // Steps through period indices first..last of a ratio-n period, checking
    // the waveform; optionally changes div_ratio after index chg_at.
    task automatic run_period(input string tag, input int n, input int first,
                              input int last, input int chg_at, input int chg_val);
        for (int i = first; i <= last; i++) begin
            step();
            chk({tag, ".clk"},  32'(out_clk),  (i < (n + 1) / 2) ? 32'd1 : 32'd0);
            chk({tag, ".tick"}, 32'(out_tick), (i == 0) ? 32'd1 : 32'd0);
            chk({tag, ".div"},  32'(cur_div),  32'(n));
            chk({tag, ".run"},  32'(running),  32'd1);
            if (i == chg_at) div_ratio = DIV_W'(chg_val);
        end
    endtask

    task automatic chk_idle(input string tag, input int exp_div);
        chk({tag, ".clk"},  32'(out_clk),  32'd0);
        chk({tag, ".tick"}, 32'(out_tick), 32'd0);
        chk({tag, ".run"},  32'(running),  32'd0);
        chk({tag, ".div"},  32'(cur_div),  32'(exp_div));
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        div_ratio = '0;
`ifdef CLKDIV_SYNC_IN_EN
        sync_in   = 1'b0;
`endif
        step();
        step();
        chk_idle("reset", 2);

        // N=4: 1100 repeating, tick at period start
        rst       = 1'b0;
        en        = 1'b1;
        div_ratio = 16'd4;
        for (int p = 0; p < 3; p++) run_period("n4", 4, 0, 3, -1, 0);

        // N=5: 11100 over 20 periods
        div_ratio = 16'd5;
        for (int p = 0; p < 20; p++) run_period("n5", 5, 0, 4, -1, 0);

        // Ratio 4 -> 6 changed at cnt=1: current period still 4 cycles
        div_ratio = 16'd4;
        run_period("chg4", 4, 0, 3, 1, 6);
        run_period("chg6", 6, 0, 5, 5, 1);

        // Ratio 1 is clamped to 2
        run_period("clamp", 2, 0, 1, -1, 0);
        run_period("clamp", 2, 0, 1, -1, 0);
        run_period("clamp", 2, 0, 1, 1, 0);

        // Ratio 0 at the boundary stops; cur_div is held
        step();
        chk_idle("stop0", 2);
        step();
        chk_idle("idle0", 2);

        // Ratio 3 restarts on the next edge
        div_ratio = 16'd3;
        run_period("n3", 3, 0, 2, 2, 8);

        // en=0 at cnt=2 with N=8 is an immediate stop
        run_period("n8", 8, 0, 2, -1, 0);
        en = 1'b0;
        step();
        chk_idle("en0", 8);
        chk("en0.cnt", 32'(u_dut.r_cnt), 32'd0);

        // Restart, then reset at cnt=3
        en = 1'b1;
        run_period("n8b", 8, 0, 3, -1, 0);
        rst = 1'b1;
        step();
        chk_idle("rstmid", 2);
        rst = 1'b0;
        en  = 1'b0;
        step();
        chk_idle("rstidle", 2);

`ifdef CLKDIV_SYNC_IN_EN
        // sync_in at cnt=6 of a 10-cycle period restarts it
        en        = 1'b1;
        div_ratio = 16'd10;
        run_period("sy10", 10, 0, 6, -1, 0);
        sync_in = 1'b1;
        run_period("sync", 10, 0, 0, -1, 0);
        sync_in = 1'b0;
        run_period("sy10a", 10, 1, 9, -1, 0);
        run_period("sy10b", 10, 0, 9, -1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
